// File: rtl/qdec_pkg.sv
// qdec_pkg
//   Shared definitions for the quadrature decoder: channel indices into the
//   rise/fall pulse vectors and the per-cycle step classification.
package qdec_pkg;

  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_Z   = 2;
  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Classify one cycle of A/B edge pulses against the levels held before
  // the edge. Forward order of (A,B) is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic step_e classify_step(
    input logic       illegal,
    input logic [2:0] rise,
    input logic [2:0] fall,
    input logic       lvl_a,
    input logic       lvl_b
  );
    step_e kind;
    kind = STEP_NONE;
    if (illegal) begin
      kind = STEP_ERR;
    end else if (rise[CH_A]) begin
      kind = lvl_b ? STEP_REV : STEP_FWD;
    end else if (fall[CH_A]) begin
      kind = lvl_b ? STEP_FWD : STEP_REV;
    end else if (rise[CH_B]) begin
      kind = lvl_a ? STEP_FWD : STEP_REV;
    end else if (fall[CH_B]) begin
      kind = lvl_a ? STEP_REV : STEP_FWD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/qdec_level_track.sv
// qdec_level_track
//   Level register for one encoder channel, driven by one-cycle rise/fall
//   pulses, plus a combinational flag for an illegal edge on this channel.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   rise, fall  one-cycle edge pulses for this channel
//   lvl         channel level before this cycle's edge (registered)
//   illegal     this cycle's pulses are inconsistent with lvl
module qdec_level_track (
  input  logic clk,
  input  logic rst_n,
  input  logic rise,
  input  logic fall,
  output logic lvl,
  output logic illegal
);

  logic lvl_d, lvl_q;

  // Simultaneous rise and fall gives no usable new level, so the old level
  // is held. A redundant edge still forces the level to the pulse value.
  always_comb begin
    lvl_d = lvl_q;
    if (rise && !fall) begin
      lvl_d = 1'b1;
    end else if (fall && !rise) begin
      lvl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign lvl     = lvl_q;
  assign illegal = (rise && fall) || (rise && lvl_q) || (fall && !lvl_q);

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder
//   x4 quadrature decoder and position counter. Tracks A/B/Z levels from
//   edge pulses, decodes steps, keeps a wrap-around position, the position
//   captured at each index (Z) rise, last direction and a saturating count
//   of illegal events. All outputs are registered (one cycle latency).
// Build option:
//   QDEC_INDEX_CLR_EN  when defined, a Z rise also restarts position from
//                      zero plus this cycle's step delta.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   rise_array, fall_array  edge pulses, bit0=A, bit1=B, bit2=Z
//   cnt_clr                 sync clear of position, index_pos, err_cnt
//   position, index_pos     position count and index-captured position
//   dir                     direction of last valid step, 1=forward
//   step, index_seen, err   one-cycle event pulses
//   err_cnt                 saturating illegal-event count
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       rise_array,
  input  logic [2:0]       fall_array,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] position,
  output logic [CNT_W-1:0] index_pos,
  output logic             dir,
  output logic             step,
  output logic             index_seen,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] chan_illegal;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    qdec_level_track u_trk (
      .clk     (clk),
      .rst_n   (rst_n),
      .rise    (rise_array[gi]),
      .fall    (fall_array[gi]),
      .lvl     (lvl[gi]),
      .illegal (chan_illegal[gi])
    );
  end

  logic             ab_both;
  logic             any_illegal;
  logic             z_rise;
  step_e            step_kind;
  logic [CNT_W-1:0] delta;
  logic [CNT_W-1:0] pos_stepped;

  logic [CNT_W-1:0] position_d, position_q;
  logic [CNT_W-1:0] index_pos_d, index_pos_q;
  logic             dir_d, dir_q;
  logic             step_d, step_q;
  logic             index_seen_d, index_seen_q;
  logic             err_d, err_q;
  logic [ERR_W-1:0] err_cnt_d, err_cnt_q;

  // Any edge on both A and B in one cycle loses the step ordering.
  assign ab_both     = (rise_array[CH_A] || fall_array[CH_A]) &&
                       (rise_array[CH_B] || fall_array[CH_B]);
  assign any_illegal = (|chan_illegal) || ab_both;

  // Index fires only on a genuine low-to-high Z transition; a redundant
  // Z rise is flagged as an error but does not recapture the index.
  assign z_rise = rise_array[CH_Z] && !fall_array[CH_Z] && !lvl[CH_Z];

  always_comb begin
    step_kind = classify_step(any_illegal, rise_array, fall_array,
                              lvl[CH_A], lvl[CH_B]);
  end

  always_comb begin
    delta = '0;
    if (step_kind == STEP_FWD) begin
      delta = CNT_W'(1);
    end else if (step_kind == STEP_REV) begin
      delta = '1;
    end
  end

  assign pos_stepped = position_q + delta;

  always_comb begin
    position_d   = position_q;
    index_pos_d  = index_pos_q;
    dir_d        = dir_q;
    step_d       = 1'b0;
    err_d        = any_illegal;
    index_seen_d = z_rise;
    err_cnt_d    = err_cnt_q;

    if (cnt_clr) begin
      position_d  = '0;
      index_pos_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (step_kind == STEP_FWD || step_kind == STEP_REV) begin
        step_d = 1'b1;
        dir_d  = (step_kind == STEP_FWD);
      end
      position_d = pos_stepped;
      if (z_rise) begin
        index_pos_d = pos_stepped;
`ifdef QDEC_INDEX_CLR_EN
        position_d  = delta;
`endif
      end
      if (any_illegal && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position_q   <= '0;
      index_pos_q  <= '0;
      dir_q        <= 1'b1;
      step_q       <= 1'b0;
      index_seen_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      position_q   <= position_d;
      index_pos_q  <= index_pos_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      index_seen_q <= index_seen_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign position   = position_q;
  assign index_pos  = index_pos_q;
  assign dir        = dir_q;
  assign step       = step_q;
  assign index_seen = index_seen_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

`ifdef QDEC_INDEX_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rise_array = '0;
  logic [2:0]  fall_array = '0;
  logic        cnt_clr = 1'b0;
  logic [15:0] position, index_pos;
  logic        dir, step, index_seen, err;
  logic [7:0]  err_cnt;

  quad_decoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rise_array(rise_array), .fall_array(fall_array),
    .cnt_clr(cnt_clr), .position(position), .index_pos(index_pos), .dir(dir),
    .step(step), .index_seen(index_seen), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: expected outputs plus channel levels.
  logic [15:0] m_pos, m_idx;
  logic        m_dir, m_step, m_err, m_iseen;
  logic [7:0]  m_errc;
  logic [2:0]  m_lvl;

  // Phase of (A,B) along the forward cycle 00,10,11,01.
  function automatic int phase(input logic a, input logic b);
    if (!a && !b) return 0;
    if (a && !b)  return 1;
    if (a && b)   return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_pos = '0; m_idx = '0; m_dir = 1'b1; m_step = 1'b0; m_err = 1'b0;
    m_iseen = 1'b0; m_errc = '0; m_lvl = '0;
  endtask

  task automatic model_update(input logic [2:0] r, input logic [2:0] f, input logic c);
    bit ill;
    bit zr;
    logic [2:0] nl;
    int d;
    ill = 0; nl = m_lvl; d = 0;
    for (int i = 0; i < 3; i++) begin
      if (r[i] && f[i]) ill = 1;
      else if (r[i]) begin if (m_lvl[i]) ill = 1; nl[i] = 1'b1; end
      else if (f[i]) begin if (!m_lvl[i]) ill = 1; nl[i] = 1'b0; end
    end
    if ((r[0] || f[0]) && (r[1] || f[1])) ill = 1;
    if (!ill) begin
      case ((phase(nl[0], nl[1]) - phase(m_lvl[0], m_lvl[1]) + 4) % 4)
        1: d = 1;
        3: d = -1;
        default: d = 0;
      endcase
    end
    zr = r[2] && !f[2] && !m_lvl[2];
    m_step = (d != 0) && !c;
    m_err = ill;
    m_iseen = zr;
    if (c) begin
      m_pos = '0; m_idx = '0; m_errc = '0;
    end else begin
      if (d != 0) m_dir = (d > 0);
      if (zr) m_idx = m_pos + 16'(d);
      if (zr && CLR_EN) m_pos = 16'(d);
      else m_pos = m_pos + 16'(d);
      if (ill && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    end
    m_lvl = nl;
  endtask

  // Edge that moves the model's (A,B) one step forward or backward.
  task automatic step_edge(input bit fwd, output logic [2:0] r, output logic [2:0] f);
    int np;
    logic na, nb;
    np = (phase(m_lvl[0], m_lvl[1]) + (fwd ? 1 : 3)) % 4;
    na = (np == 1 || np == 2);
    nb = (np == 2 || np == 3);
    r = '0; f = '0;
    if (na != m_lvl[0]) begin if (na) r[0] = 1'b1; else f[0] = 1'b1; end
    else begin if (nb) r[1] = 1'b1; else f[1] = 1'b1; end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] f, input logic c);
    @(negedge clk);
    rise_array = r; fall_array = f; cnt_clr = c;
    @(posedge clk);
    #1;
    model_update(r, f, c);
    rise_array = '0; fall_array = '0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec += 7;
    if (position !== 16'h0) begin n_err++; $display("FAIL reset_position: got %0h exp 0", position); end
    if (index_pos !== 16'h0) begin n_err++; $display("FAIL reset_index_pos: got %0h exp 0", index_pos); end
    if (dir !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %b exp 1", dir); end
    if (step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %b exp 0", step); end
    if (index_seen !== 1'b0) begin n_err++; $display("FAIL reset_index_seen: got %b exp 0", index_seen); end
    if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", err); end
    if (err_cnt !== 8'h0) begin n_err++; $display("FAIL reset_err_cnt: got %0h exp 0", err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    logic [2:0] seq_r [4] = '{3'b001, 3'b010, 3'b000, 3'b000};
    logic [2:0] seq_f [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
    int steps;
    steps = 0;
    for (int k = 0; k < 3; k++) begin
      for (int e = 0; e < 4; e++) begin
        drive(seq_r[e], seq_f[e], 1'b0);
        if (step === 1'b1) steps++;
        repeat (3) begin
          drive(3'b000, 3'b000, 1'b0);
          if (step === 1'b1) steps++;
        end
      end
    end
    n_vec += 4;
    if (position !== 16'd12) begin n_err++; $display("FAIL fwd_position: got %0h exp c", position); end
    if (dir !== 1'b1) begin n_err++; $display("FAIL fwd_dir: got %b exp 1", dir); end
    if (steps != 12) begin n_err++; $display("FAIL fwd_step_pulses: got %0d exp 12", steps); end
    if (err_cnt !== 8'h0) begin n_err++; $display("FAIL fwd_err_cnt: got %0h exp 0", err_cnt); end
  endtask

  task automatic test_reverse();
    logic [2:0] seq_r [4] = '{3'b010, 3'b001, 3'b000, 3'b000};
    logic [2:0] seq_f [4] = '{3'b000, 3'b000, 3'b010, 3'b001};
    drive(3'b000, 3'b000, 1'b1);
    for (int e = 0; e < 4; e++) begin
      drive(seq_r[e], seq_f[e], 1'b0);
      n_vec++;
      if (step !== 1'b1) begin n_err++; $display("FAIL rev_step_pulse: got %b exp 1", step); end
      repeat (3) drive(3'b000, 3'b000, 1'b0);
    end
    n_vec += 2;
    if (position !== 16'hFFFC) begin n_err++; $display("FAIL rev_position: got %0h exp fffc", position); end
    if (dir !== 1'b0) begin n_err++; $display("FAIL rev_dir: got %b exp 0", dir); end
  endtask

  task automatic test_errors();
    drive(3'b000, 3'b000, 1'b1);
    drive(3'b011, 3'b000, 1'b0);
    n_vec += 4;
    if (err !== 1'b1) begin n_err++; $display("FAIL ab_same_err: got %b exp 1", err); end
    if (err_cnt !== 8'd1) begin n_err++; $display("FAIL ab_same_err_cnt: got %0h exp 1", err_cnt); end
    if (position !== 16'h0) begin n_err++; $display("FAIL ab_same_position: got %0h exp 0", position); end
    if (step !== 1'b0) begin n_err++; $display("FAIL ab_same_step: got %b exp 0", step); end
    drive(3'b000, 3'b000, 1'b0);
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL err_one_cycle: got %b exp 0", err); end
    drive(3'b001, 3'b000, 1'b0);
    n_vec += 2;
    if (err_cnt !== 8'd2) begin n_err++; $display("FAIL double_rise_err_cnt: got %0h exp 2", err_cnt); end
    if (position !== 16'h0) begin n_err++; $display("FAIL double_rise_position: got %0h exp 0", position); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 300; k++) drive(3'b001, 3'b001, 1'b0);
    n_vec += 2;
    if (err_cnt !== 8'hFF) begin n_err++; $display("FAIL err_cnt_saturate: got %0h exp ff", err_cnt); end
    if (err !== 1'b1) begin n_err++; $display("FAIL err_back_to_back: got %b exp 1", err); end
  endtask

  task automatic test_index();
    logic [2:0] r, f;
    drive(3'b000, 3'b000, 1'b1);
    if (m_lvl[2]) drive(3'b000, 3'b100, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step_edge(1'b1, r, f);
      drive(r, f, 1'b0);
    end
    drive(3'b100, 3'b000, 1'b0);
    n_vec += 3;
    if (index_pos !== 16'd5) begin n_err++; $display("FAIL index_pos_capture: got %0h exp 5", index_pos); end
    if (index_seen !== 1'b1) begin n_err++; $display("FAIL index_seen_pulse: got %b exp 1", index_seen); end
    if (position !== (CLR_EN ? 16'd0 : 16'd5)) begin n_err++; $display("FAIL index_position: got %0h exp %0h", position, CLR_EN ? 16'd0 : 16'd5); end
    drive(3'b000, 3'b100, 1'b0);
    n_vec++;
    if (index_seen !== 1'b0) begin n_err++; $display("FAIL index_fall_no_pulse: got %b exp 0", index_seen); end
    // Z rise together with a forward step.
    step_edge(1'b1, r, f);
    drive(r | 3'b100, f, 1'b0);
    n_vec += 2;
    if (index_pos !== m_idx) begin n_err++; $display("FAIL index_with_step: got %0h exp %0h", index_pos, m_idx); end
    if (position !== m_pos) begin n_err++; $display("FAIL index_step_position: got %0h exp %0h", position, m_pos); end
  endtask

  task automatic test_clr();
    logic [2:0] r, f;
    logic exp_dir;
    drive(3'b010, 3'b010, 1'b0);
    step_edge(1'b0, r, f);
    exp_dir = m_dir;
    drive(r, f, 1'b1);
    n_vec += 5;
    if (position !== 16'h0) begin n_err++; $display("FAIL clr_position: got %0h exp 0", position); end
    if (index_pos !== 16'h0) begin n_err++; $display("FAIL clr_index_pos: got %0h exp 0", index_pos); end
    if (err_cnt !== 8'h0) begin n_err++; $display("FAIL clr_err_cnt: got %0h exp 0", err_cnt); end
    if (step !== 1'b0) begin n_err++; $display("FAIL clr_step_discarded: got %b exp 0", step); end
    if (dir !== exp_dir) begin n_err++; $display("FAIL clr_dir_kept: got %b exp %b", dir, exp_dir); end
  endtask

  task automatic test_wrap();
    logic [2:0] r, f;
    int steps;
    steps = 0;
    drive(3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 32767; k++) begin
      step_edge(1'b1, r, f);
      drive(r, f, 1'b0);
      if (step === 1'b1) steps++;
    end
    n_vec += 2;
    if (position !== 16'h7FFF) begin n_err++; $display("FAIL wrap_pre_position: got %0h exp 7fff", position); end
    if (steps != 32767) begin n_err++; $display("FAIL back_to_back_steps: got %0d exp 32767", steps); end
    step_edge(1'b1, r, f);
    drive(r, f, 1'b0);
    n_vec++;
    if (position !== 16'h8000) begin n_err++; $display("FAIL wrap_position: got %0h exp 8000", position); end
    drive(3'b000, 3'b000, 1'b1);
    step_edge(1'b0, r, f);
    drive(r, f, 1'b0);
    n_vec++;
    if (position !== 16'hFFFF) begin n_err++; $display("FAIL wrap_under_position: got %0h exp ffff", position); end
  endtask

  task automatic test_async_reset();
    logic [2:0] r, f;
    for (int k = 0; k < 2; k++) begin
      step_edge(1'b1, r, f);
      drive(r, f, 1'b0);
    end
    drive(3'b100, 3'b000, 1'b0);
    drive(3'b011, 3'b000, 1'b0);
    @(negedge clk);
    rise_array = 3'b001;
    #2 rst_n = 1'b0;
    #1;
    n_vec += 6;
    if (position !== 16'h0) begin n_err++; $display("FAIL async_position: got %0h exp 0", position); end
    if (index_pos !== 16'h0) begin n_err++; $display("FAIL async_index_pos: got %0h exp 0", index_pos); end
    if (dir !== 1'b1) begin n_err++; $display("FAIL async_dir: got %b exp 1", dir); end
    if (err !== 1'b0) begin n_err++; $display("FAIL async_err: got %b exp 0", err); end
    if (err_cnt !== 8'h0) begin n_err++; $display("FAIL async_err_cnt: got %0h exp 0", err_cnt); end
    if (step !== 1'b0) begin n_err++; $display("FAIL async_step: got %b exp 0", step); end
    rise_array = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b001, 3'b000, 1'b0);
    n_vec += 3;
    if (position !== 16'd1) begin n_err++; $display("FAIL post_reset_position: got %0h exp 1", position); end
    if (dir !== 1'b1) begin n_err++; $display("FAIL post_reset_dir: got %b exp 1", dir); end
    if (step !== 1'b1) begin n_err++; $display("FAIL post_reset_step: got %b exp 1", step); end
  endtask

  task automatic test_random();
    logic [2:0] r, f;
    logic c;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        step_edge($urandom_range(0, 1) == 1, r, f);
        if ($urandom_range(0, 7) == 0) begin
          if (m_lvl[2]) f[2] = 1'b1; else r[2] = 1'b1;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          r[i] = ($urandom_range(0, 5) == 0);
          f[i] = ($urandom_range(0, 5) == 0);
        end
      end
      c = ($urandom_range(0, 63) == 0);
      drive(r, f, c);
      n_vec += 7;
      if (position !== m_pos) begin n_err++; $display("FAIL rnd_position cyc %0d: got %0h exp %0h", k, position, m_pos); end
      if (index_pos !== m_idx) begin n_err++; $display("FAIL rnd_index_pos cyc %0d: got %0h exp %0h", k, index_pos, m_idx); end
      if (dir !== m_dir) begin n_err++; $display("FAIL rnd_dir cyc %0d: got %b exp %b", k, dir, m_dir); end
      if (step !== m_step) begin n_err++; $display("FAIL rnd_step cyc %0d: got %b exp %b", k, step, m_step); end
      if (index_seen !== m_iseen) begin n_err++; $display("FAIL rnd_index_seen cyc %0d: got %b exp %b", k, index_seen, m_iseen); end
      if (err !== m_err) begin n_err++; $display("FAIL rnd_err cyc %0d: got %b exp %b", k, err, m_err); end
      if (err_cnt !== m_errc) begin n_err++; $display("FAIL rnd_err_cnt cyc %0d: got %0h exp %0h", k, err_cnt, m_errc); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_errors();
    test_saturate();
    test_index();
    test_clr();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
